oscope_capture_mc: RTL and testbench

- Multi-channel triggered capture buffer for the oscope application. It is the parametrised successor of the fixed two-channel scope path: channel count, sample width and depth are all generic.
- Takes NCH parallel ADC streams and arms on a local-bus command. It fills a programmable pretrigger window, waits for a level-crossing or external trigger, then finishes the post-trigger window.
- Capture memory reads back oldest-first through a local-bus style read port, all on one clock.

---
 rtl/oscope_capture_mc.sv | 259 +++++++++++++++++++++++++
 tb/tb_oscope_capture_mc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oscope_capture_mc.sv
// oscope_capture_mc: multi-channel triggered capture buffer.
//
// Arms on a one-cycle pulse and fills a pretrigger window of P samples.
// It then waits in a ring-buffer mode for an external or level-crossing
// trigger, and finishes with DEPTH-P post-trigger samples, the trigger
// sample being the first of them. The captured window reads back
// oldest-first through a pipelined read port with two cycles of latency.
//
// Optional build macro: OSCOPE_CAPTURE_DECIMATE_EN. When it is defined,
// only every dec_factor-th adc_valid sample is accepted.
//
// Ports:
//   clk, reset   sole clock; synchronous active-high reset
//   adc_data     NCH packed samples, channel k at [k*DW +: DW]
//   adc_valid    qualifies adc_data
//   arm          one-cycle pulse, starts or restarts a capture
//   trig_ext     external trigger, sampled with accepted samples
//   trig_src     0 ext, 1 rising, 2 falling, 3 ext | rising
//   trig_chan    channel for level triggering (>= NCH disables level)
//   trig_level   signed threshold
//   pretrig      pretrigger sample count, latched on arm
//   dec_factor   decimation factor (decimation build only)
//   rd_addr      {channel, index}; index 0 is the oldest sample
//   rd_en        read strobe
//   rd_data      read result, 2 cycles after rd_en
//   rd_valid     marks rd_data
//   busy         capture in progress (PRE, WAIT, POST)
//   done         capture complete
//   trig_seen    sticky trigger-accepted flag
module oscope_capture_mc #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DW     = 16,
    parameter int unsigned BUF_AW = 13,
    parameter int unsigned CW     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*DW-1:0]    adc_data,
    input  logic                 adc_valid,
    input  logic                 arm,
    input  logic                 trig_ext,
    input  logic [1:0]           trig_src,
    input  logic [CW-1:0]        trig_chan,
    input  logic [DW-1:0]        trig_level,
    input  logic [BUF_AW-1:0]    pretrig,
    input  logic [7:0]           dec_factor,
    input  logic [CW+BUF_AW-1:0] rd_addr,
    input  logic                 rd_en,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 trig_seen
);

    localparam int unsigned DEPTH = 2 ** BUF_AW;

    typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

    state_e              state_q, state_d;
    logic [BUF_AW-1:0]   wptr_q, wptr_d;
    logic [BUF_AW-1:0]   start_q, start_d;
    logic [BUF_AW-1:0]   p_q, p_d;
    logic [BUF_AW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [BUF_AW:0]     post_cnt_q, post_cnt_d;
    logic [BUF_AW:0]     post_target;
    logic                trig_seen_q, trig_seen_d;
    logic                have_prev_q, have_prev_d;
    logic [NCH*DW-1:0]   prev_q, prev_d;
    logic                capturing, accept, wen, trig_hit;

    assign capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    // The pretrig port is BUF_AW wide, so P is already bounded by DEPTH-1.
    assign post_target = (BUF_AW+1)'(DEPTH) - {1'b0, p_q};

`ifdef OSCOPE_CAPTURE_DECIMATE_EN
    logic [7:0] dec_q, dec_cnt_q, dec_cnt_d;
    logic       dec_take;

    always_comb begin
        dec_take  = (dec_q <= 8'd1) || (dec_cnt_q == dec_q - 8'd1);
        dec_cnt_d = dec_cnt_q;
        if (arm) begin
            dec_cnt_d = '0;
        end else if (capturing && adc_valid) begin
            dec_cnt_d = dec_take ? '0 : dec_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q     <= '0;
            dec_cnt_q <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            if (arm) dec_q <= dec_factor;
        end
    end

    assign accept = capturing && adc_valid && dec_take;
`else
    logic unused_dec;
    assign unused_dec = ^dec_factor;
    assign accept = capturing && adc_valid;
`endif

    // Trigger detection on the selected channel against its previous accepted sample.
    logic signed [DW-1:0] trig_cur, trig_prev, level_s;
    logic                 level_ok, rise, fall;

    always_comb begin
        trig_cur  = '0;
        trig_prev = '0;
        level_ok  = 1'b0;
        level_s   = trig_level;
        for (int k = 0; k < NCH; k++) begin
            if (trig_chan == CW'(k)) begin
                trig_cur  = adc_data[k*DW +: DW];
                trig_prev = prev_q[k*DW +: DW];
                level_ok  = have_prev_q;
            end
        end
        rise = level_ok && (trig_prev < level_s) && (trig_cur >= level_s);
        fall = level_ok && (trig_prev > level_s) && (trig_cur <= level_s);
        case (trig_src)
            2'd0:    trig_hit = trig_ext;
            2'd1:    trig_hit = rise;
            2'd2:    trig_hit = fall;
            default: trig_hit = trig_ext || rise;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        start_d     = start_q;
        p_d         = p_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_seen_d = trig_seen_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        wen         = 1'b0;
        if (arm) begin
            // Arm wins over any sample or trigger presented in the same cycle.
            p_d         = pretrig;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            wptr_d      = '0;
            trig_seen_d = 1'b0;
            have_prev_d = 1'b0;
            state_d     = (pretrig == '0) ? StWait : StPre;
        end else if (accept) begin
            wen         = 1'b1;
            wptr_d      = wptr_q + BUF_AW'(1);
            prev_d      = adc_data;
            have_prev_d = 1'b1;
            case (state_q)
                StPre: begin
                    pre_cnt_d = pre_cnt_q + BUF_AW'(1);
                    if (pre_cnt_d == p_q) state_d = StWait;
                end
                StWait: begin
                    if (trig_hit) begin
                        trig_seen_d = 1'b1;
                        post_cnt_d  = (BUF_AW+1)'(1);
                        if (post_target == (BUF_AW+1)'(1)) begin
                            state_d = StDone;
                            start_d = wptr_d;
                        end else begin
                            state_d = StPost;
                        end
                    end
                end
                StPost: begin
                    post_cnt_d = post_cnt_q + (BUF_AW+1)'(1);
                    if (post_cnt_d == post_target) begin
                        state_d = StDone;
                        // Next write slot is the oldest sample of the full window.
                        start_d = wptr_d;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            start_q     <= '0;
            p_q         <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_seen_q <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            start_q     <= start_d;
            p_q         <= p_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_seen_q <= trig_seen_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
        end
    end

    assign busy      = capturing;
    assign done      = (state_q == StDone);
    assign trig_seen = trig_seen_q;

    // Storage and read path: registered RAM read, then channel mux into an output register.
    logic [BUF_AW-1:0] rd_phys;
    logic [NCH*DW-1:0] ram_rd;
    logic [CW-1:0]     rd_ch_q;
    logic              rd_v1_q;
    logic [DW-1:0]     rd_mux;

    assign rd_phys = start_q + rd_addr[BUF_AW-1:0];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wen) mem[wptr_q] <= adc_data[k*DW +: DW];
            if (rd_en) rd_q <= mem[rd_phys];
        end

        assign ram_rd[k*DW +: DW] = rd_q;
    end

    // Channels without a RAM fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_ch_q == CW'(k)) rd_mux = ram_rd[k*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1_q  <= 1'b0;
            rd_ch_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_v1_q  <= rd_en;
            if (rd_en) rd_ch_q <= rd_addr[CW+BUF_AW-1 -: CW];
            rd_valid <= rd_v1_q;
            if (rd_v1_q) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_oscope_capture_mc.sv
module tb_oscope_capture_mc;

    localparam int NCH    = 2;
    localparam int DW     = 16;
    localparam int BUF_AW = 4;
    localparam int CW     = 3;
    localparam int DEPTH  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH*DW-1:0]    adc_data;
    logic                 adc_valid;
    logic                 arm;
    logic                 trig_ext;
    logic [1:0]           trig_src;
    logic [CW-1:0]        trig_chan;
    logic [DW-1:0]        trig_level;
    logic [BUF_AW-1:0]    pretrig;
    logic [7:0]           dec_factor;
    logic [CW+BUF_AW-1:0] rd_addr;
    logic                 rd_en;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;
    logic                 trig_seen;

    oscope_capture_mc #(
        .NCH    (NCH),
        .DW     (DW),
        .BUF_AW (BUF_AW),
        .CW     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .arm        (arm),
        .trig_ext   (trig_ext),
        .trig_src   (trig_src),
        .trig_chan  (trig_chan),
        .trig_level (trig_level),
        .pretrig    (pretrig),
        .dec_factor (dec_factor),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .trig_seen  (trig_seen)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Read scoreboard: expected data and the cycle it must appear on.
    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    int      hist[$];

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_e.data));
                check("rd_latency", 32'(cycle), 32'(mon_e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            check("rd_valid_missing", 32'(rd_valid), 32'd1);
            mon_e = sb.pop_front();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ch0 carries v, ch1 carries -v.
    task automatic sample(int v, bit ext);
        adc_data  = {16'(-v), 16'(v)};
        adc_valid = 1'b1;
        trig_ext  = ext;
        tick();
        adc_valid = 1'b0;
        trig_ext  = 1'b0;
        hist.push_back(v);
    endtask

    task automatic do_arm(bit noise);
        arm       = 1'b1;
        adc_valid = noise;
        trig_ext  = noise;
        adc_data  = {16'd500, 16'd500};
        tick();
        arm       = 1'b0;
        adc_valid = 1'b0;
        trig_ext  = 1'b0;
        hist.delete();
    endtask

    task automatic rd(int ch, int idx, logic [15:0] exp);
        rd_exp_t e;
        rd_addr = {3'(ch), 4'(idx)};
        rd_en   = 1'b1;
        e.data  = exp;
        e.due   = cycle + 2;
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    // Compare the whole window of both channels against the last DEPTH accepted samples.
    task automatic read_window();
        int n;
        n = hist.size();
        for (int i = 0; i < DEPTH; i++) rd(0, i, 16'(hist[n-DEPTH+i]));
        for (int i = 0; i < DEPTH; i++) rd(1, i, 16'(-hist[n-DEPTH+i]));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        adc_data   = '0;
        adc_valid  = 1'b0;
        arm        = 1'b0;
        trig_ext   = 1'b0;
        trig_src   = 2'd1;
        trig_chan  = 3'd0;
        trig_level = 16'd100;
        pretrig    = 4'd4;
        dec_factor = 8'd0;
        rd_addr    = '0;
        rd_en      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_trig_seen", 32'(trig_seen), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Rising trigger at 100 on a ramp of step 10, P = 4.
        do_arm(1'b0);
        check("t1_busy_armed", 32'(busy), 32'd1);
        for (int v = 0; v <= 210; v += 10) begin
            sample(v, 1'b0);
            if (v == 90)  check("t1_no_trig_before", 32'(trig_seen), 32'd0);
            if (v == 100) check("t1_trig_at_100", 32'(trig_seen), 32'd1);
            if (v == 200) check("t1_not_done_early", 32'(done), 32'd0);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        rd(0, 4, 16'd100);
        rd(0, 0, 16'd60);
        rd(0, 15, 16'd210);
        rd(7, 3, 16'd0);
        drain();
        read_window();
        // Back-to-back reads, oldest-first.
        rd(0, 0, 16'd60);
        rd(0, 1, 16'd70);
        rd(0, 2, 16'd80);
        drain();

        // Largest representable pretrigger window: one post-trigger sample.
        pretrig    = 4'd15;
        trig_level = 16'd145;
        do_arm(1'b0);
        for (int v = 0; v <= 150; v += 10) begin
            sample(v, 1'b0);
            if (v == 140) begin
                check("t2_no_trig_pre", 32'(trig_seen), 32'd0);
                check("t2_not_done", 32'(done), 32'd0);
            end
        end
        check("t2_trig", 32'(trig_seen), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        rd(0, 15, 16'd150);
        rd(0, 0, 16'd0);
        drain();

        // Falling trigger, P = 0; first sample equals the level but must not trigger.
        pretrig    = 4'd0;
        trig_src   = 2'd2;
        trig_level = 16'd100;
        do_arm(1'b0);
        check("t3_busy", 32'(busy), 32'd1);
        sample(100, 1'b0);
        check("t3_first_no_trig", 32'(trig_seen), 32'd0);
        sample(120, 1'b0);
        sample(140, 1'b0);
        sample(130, 1'b0);
        sample(110, 1'b0);
        check("t3_above_no_trig", 32'(trig_seen), 32'd0);
        sample(90, 1'b0);
        check("t3_fall_trig", 32'(trig_seen), 32'd1);
        for (int v = 80; v >= -60; v -= 10) begin
            if (v == -60) check("t3_not_done", 32'(done), 32'd0);
            sample(v, 1'b0);
        end
        check("t3_done", 32'(done), 32'd1);
        rd(0, 0, 16'd90);
        drain();
        read_window();

        // External trigger, re-arm during POST with a coincident trigger.
        pretrig  = 4'd4;
        trig_src = 2'd0;
        do_arm(1'b0);
        for (int v = 0; v < 4; v++) sample(v, 1'b1);
        check("t4_pre_ignores_ext", 32'(trig_seen), 32'd0);
        sample(4, 1'b1);
        check("t4_ext_trig", 32'(trig_seen), 32'd1);
        sample(5, 1'b0);
        sample(6, 1'b0);
        do_arm(1'b1);
        check("t4_rearm_busy", 32'(busy), 32'd1);
        check("t4_rearm_clear", 32'(trig_seen), 32'd0);
        for (int v = 10; v < 14; v++) sample(v, 1'b1);
        check("t4_rearm_pre", 32'(trig_seen), 32'd0);
        sample(14, 1'b1);
        check("t4_rearm_trig", 32'(trig_seen), 32'd1);
        for (int v = 15; v < 26; v++) begin
            if (v == 25) check("t4_not_done", 32'(done), 32'd0);
            sample(v, 1'b0);
        end
        check("t4_done", 32'(done), 32'd1);
        read_window();

        // Level disabled by an out-of-range channel in mode 3; ext still triggers.
        pretrig    = 4'd0;
        trig_src   = 2'd3;
        trig_chan  = 3'd5;
        trig_level = 16'd0;
        do_arm(1'b0);
        sample(-20, 1'b0);
        sample(20, 1'b0);
        check("t5_level_disabled", 32'(trig_seen), 32'd0);
        sample(30, 1'b1);
        check("t5_ext_mode3", 32'(trig_seen), 32'd1);

        // Reset mid-POST with a read in flight: rd_valid must be dropped.
        rd_addr = '0;
        rd_en   = 1'b1;
        tick();
        rd_en = 1'b0;
        reset = 1'b1;
        tick();
        check("t6_rd_valid_dropped", 32'(rd_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_trig_seen", 32'(trig_seen), 32'd0);
        reset = 1'b0;
        tick();
        check("t6_rd_valid_after", 32'(rd_valid), 32'd0);

        // Reset mid-WAIT.
        trig_src = 2'd0;
        do_arm(1'b0);
        sample(1, 1'b0);
        sample(2, 1'b0);
        check("t7_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_done", 32'(done), 32'd0);

`ifdef OSCOPE_CAPTURE_DECIMATE_EN
        // Every 4th sample accepted: 3, 7, 11, ... ; trigger on 51.
        dec_factor = 8'd4;
        pretrig    = 4'd2;
        trig_src   = 2'd1;
        trig_chan  = 3'd0;
        trig_level = 16'd50;
        do_arm(1'b0);
        for (int v = 0; v <= 103; v++) begin
            sample(v, 1'b0);
            if (v == 50) check("dec_no_trig", 32'(trig_seen), 32'd0);
            if (v == 51) check("dec_trig", 32'(trig_seen), 32'd1);
            if (v == 102) check("dec_not_done", 32'(done), 32'd0);
        end
        check("dec_done", 32'(done), 32'd1);
        rd(0, 0, 16'd43);
        rd(0, 1, 16'd47);
        rd(0, 2, 16'd51);
        rd(0, 15, 16'd103);
        drain();
`endif

        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
